rr_arbiter_8_dec: RTL and testbench
===================================

// Module: rr_arbiter_8_dec
// PURPOSE
//  - Round-robin arbiter that shares one resource among 8 requesters.
//  - Issues a one-hot grant (3-to-8 decoded form, En-gated) plus the encoded winner index.
//  - Holds each grant until the owner finishes, the owner withdraws, or a hold timeout expires.
//  - Sits in front of any shared datapath whose per-channel enables are one-hot decoded.
// PARAMETERS
//  HOLD_MAX  15  max consecutive grant cycles per owner; 0 = no timeout
//  CW        $clog2(HOLD_MAX+1) (min 1)  hold-counter width; derived, do not override
// PORTS
//  Clk      in   1  clock; all state updates on rising edge
//  Rst      in   1  synchronous reset, active-high
//  En       in   1  arbiter enable; 0 = no new grant, and any active grant is aborted
//  Req      in   8  request per channel; level-sensitive; must stay high while served
//  Done     in   1  owner finished; 1-cycle pulse; sampled only while Valid=1
//  Gnt      out  8  one-hot grant = decode(GntIdx) & {8{Valid}}; all 0 when idle
//  GntIdx   out  3  index of current owner; holds last owner when idle
//  Valid    out  1  a grant is active
//  Timeout  out  1  1-cycle pulse: last grant was revoked by the hold limit
// BEHAVIOUR
//  - Reset (Rst=1 at an edge): state=IDLE, Gnt=0, GntIdx=0, Valid=0, Timeout=0, Ptr=0, HoldCnt=0.
//    Rst overrides every other input, including mid-grant.
//  - Ptr (3b, internal): highest-priority channel for the next arbitration.
//  - All outputs are registered. Gnt is driven from registered Valid/GntIdx, so it is glitch-free.
//  - State IDLE:
//    - If En=1 and |Req=1: winner = first set Req bit scanning Ptr, Ptr+1, ... mod 8 (7 wraps to 0).
//    - At the next edge: GntIdx=winner, Valid=1, HoldCnt=0, state -> GRANT.
//    - Latency: 1 cycle from the Req sample to Gnt.
//    - If En=0 or Req=0: remain in IDLE with all outputs 0.
//  - State GRANT: Gnt and GntIdx stay stable. HoldCnt increments once per cycle while in GRANT.
//    Release conditions, in priority order, evaluated each cycle:
//    1. En=0: abort; Ptr unchanged; Timeout=0.
//    2. Done=1: normal release; Ptr = GntIdx+1 mod 8.
//    3. Req[GntIdx]=0: withdrawal; Ptr = GntIdx+1 mod 8.
//    4. HOLD_MAX!=0 and HoldCnt==HOLD_MAX-1: revoke; Ptr = GntIdx+1 mod 8; Timeout=1.
//  - On release, at the next edge: Valid=0, Gnt=0, state -> IDLE.
//    Timeout (case 4 only) is high in that same first idle cycle, for exactly 1 cycle.
//  - The owner therefore holds Gnt for at most HOLD_MAX cycles.
//  - At least 1 idle cycle (Gnt=0) separates consecutive grants, even when the same channel re-requests.
//  - Done and the timeout in the same cycle: treated as Done, Timeout stays 0.
//  - Done while IDLE: ignored.
//  - Req changes on channels other than the owner during GRANT: no effect until the next arbitration.
//  - Invariants:
//    - Gnt has at most one bit set.
//    - Gnt != 0 implies Valid=1 and Gnt[GntIdx]=1.
//    - Timeout=1 implies Valid=0.
// TESTING
//  1. Rst, then En=1, Req=8'h01 -> next cycle Gnt=8'h01, GntIdx=0, Valid=1;
//     Done pulse -> next cycle Gnt=0, Valid=0, next winner search starts at 1.
//  2. Req=8'hFF held, Done pulsed every grant cycle -> GntIdx sequence 0,1,...,7,0,
//     each grant 1 cycle, 1 idle cycle between grants.
//  3. Ptr=6 (after serving ch5), Req=8'b0010_0001 -> winner ch0 (wrap), not ch5;
//     then Req=8'b0010_0000 -> ch5.
//  4. HOLD_MAX=15, Req[3] held, no Done -> Gnt=8'h08 for exactly 15 cycles;
//     Timeout=1 in the following cycle with Gnt=0; next scan starts at ch4.
//  5. Mid-grant on ch2:
//     - drop En -> next cycle Gnt=0, Timeout=0, Ptr stays 2.
//     - repeat, but assert Rst instead -> all outputs 0 and Ptr=0.
//  6. Owner ch4 drops Req[4] mid-grant while Req[1] stays high ->
//     Gnt=0 for 1 cycle, then Gnt=8'h02; Done and the timeout coincident -> Timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter_8_dec.sv
// Round-robin arbiter for 8 requesters with a one-hot (decoded) grant, an encoded winner
// index, and per-grant hold limiting. All outputs come straight from registers.
module rr_arbiter_8_dec #(
  parameter int HOLD_MAX = 15,
  localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1)
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  input  logic [7:0] Req,
  input  logic       Done,
  output logic [7:0] Gnt,
  output logic [2:0] GntIdx,
  output logic       Valid,
  output logic       Timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  state_t        state_r, state_n;
  logic [2:0]    ptr_r, ptr_n;
  logic [2:0]    gnt_idx_r, gnt_idx_n;
  logic          valid_r, valid_n;
  logic          timeout_r, timeout_n;
  logic [7:0]    gnt_r, gnt_n;
  logic [CW-1:0] hold_cnt_r, hold_cnt_n;
  logic [3:0]    pick_s;

  function automatic logic [7:0] decode3(input logic [2:0] idx);
    decode3 = 8'h01 << idx;
  endfunction

  // Returns {found, index}; scanning downward lets the channel closest to ptr win.
  function automatic logic [3:0] pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    pick = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) begin
        pick = {1'b1, idx};
      end
    end
  endfunction

  assign pick_s = pick(Req, ptr_r);

  // Next-state, release priority and output computation
  always_comb begin
    state_n    = state_r;
    ptr_n      = ptr_r;
    gnt_idx_n  = gnt_idx_r;
    valid_n    = valid_r;
    timeout_n  = 1'b0;
    hold_cnt_n = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (En && pick_s[3]) begin
          gnt_idx_n  = pick_s[2:0];
          valid_n    = 1'b1;
          hold_cnt_n = '0;
          state_n    = GRANT;
        end else begin
          valid_n = 1'b0;
        end
      end
      GRANT: begin
        hold_cnt_n = hold_cnt_r + CW'(1);
        if (!En) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end else if (Done || !Req[gnt_idx_r]) begin
          ptr_n   = gnt_idx_r + 3'd1;
          valid_n = 1'b0;
          state_n = IDLE;
        end else if ((HOLD_MAX != 0) && (hold_cnt_r == HOLD_LAST)) begin
          ptr_n     = gnt_idx_r + 3'd1;
          timeout_n = 1'b1;
          valid_n   = 1'b0;
          state_n   = IDLE;
        end else begin
          valid_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
    gnt_n = valid_n ? decode3(gnt_idx_n) : 8'h00;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r    <= IDLE;
      ptr_r      <= 3'd0;
      gnt_idx_r  <= 3'd0;
      valid_r    <= 1'b0;
      timeout_r  <= 1'b0;
      gnt_r      <= 8'h00;
      hold_cnt_r <= '0;
    end else begin
      state_r    <= state_n;
      ptr_r      <= ptr_n;
      gnt_idx_r  <= gnt_idx_n;
      valid_r    <= valid_n;
      timeout_r  <= timeout_n;
      gnt_r      <= gnt_n;
      hold_cnt_r <= hold_cnt_n;
    end
  end

  assign Gnt     = gnt_r;
  assign GntIdx  = gnt_idx_r;
  assign Valid   = valid_r;
  assign Timeout = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_8_dec.sv
// Bench for rr_arbiter_8_dec: directed vector table, hand-written corner sequences,
// then random stimulus against a cycle-level behavioural model.
module tb_rr_arbiter_8_dec;

  localparam int HOLD = 15;

  logic       Clk;
  logic       Rst;
  logic       En;
  logic [7:0] Req;
  logic       Done;
  logic [7:0] Gnt;
  logic [2:0] GntIdx;
  logic       Valid;
  logic       Timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  // model state
  int m_owner;
  int m_last;
  int m_ptr;
  int m_held;
  bit m_to;

  rr_arbiter_8_dec dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Req(Req), .Done(Done),
    .Gnt(Gnt), .GntIdx(GntIdx), .Valid(Valid), .Timeout(Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void add(logic rst, logic en, logic [7:0] req, logic done,
                              logic [7:0] gnt, logic [2:0] idx, logic valid, logic to);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req; v.done = done;
    v.gnt = gnt; v.idx = idx; v.valid = valid; v.to = to;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic rst, input logic en, input logic [7:0] req, input logic done);
    Rst = rst; En = en; Req = req; Done = done;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] gnt, input logic [2:0] idx,
                       input logic valid, input logic to);
    total++;
    if ({Gnt, GntIdx, Valid, Timeout} !== {gnt, idx, valid, to}) begin
      bad++;
      $display("FAIL %s: got Gnt=%h GntIdx=%0d Valid=%b Timeout=%b, want Gnt=%h GntIdx=%0d Valid=%b Timeout=%b",
               name, Gnt, GntIdx, Valid, Timeout, gnt, idx, valid, to);
    end
  endtask

  // Predicts the outputs after the coming edge from the rules, using plain integers.
  function automatic void model_step(logic rst, logic en, logic [7:0] req, logic done);
    if (rst) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (m_owner < 0) begin
      if (en && req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr + k) % 8;
          if (req[c]) begin
            m_owner = c; m_last = c; m_held = 1;
            break;
          end
        end
      end
    end else if (!en) begin
      m_owner = -1;
    end else if (done || !req[m_owner]) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1;
    end else if (HOLD != 0 && m_held == HOLD) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1;
    end else begin
      m_held++;
    end
  endfunction

  task automatic hold_to_limit(input string name, input logic last_done);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h08, 1'b0);
    check({name, "_first"}, 8'h08, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < HOLD - 1; i++) begin
      step(1'b0, 1'b1, 8'h08, 1'b0);
      check({name, "_hold"}, 8'h08, 3'd3, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 8'h08, last_done);
  endtask

  initial begin
    Rst = 1'b1; En = 1'b0; Req = 8'h00; Done = 1'b0;

    // single request, grant, done
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h01, 0, 8'h01, 0, 1, 0);
    add(0, 1, 8'h01, 1, 8'h00, 0, 0, 0);
    // full rotation with Req=FF, Done every grant cycle
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      add(0, 1, 8'hFF, 0, 8'h01 << (k % 8), 3'(k % 8), 1, 0);
      add(0, 1, 8'hFF, 1, 8'h00, 3'(k % 8), 0, 0);
    end
    // pointer wrap after serving ch5
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h20, 0, 8'h20, 5, 1, 0);
    add(0, 1, 8'h20, 1, 8'h00, 5, 0, 0);
    add(0, 1, 8'h21, 0, 8'h01, 0, 1, 0);
    add(0, 1, 8'h21, 1, 8'h00, 0, 0, 0);
    add(0, 1, 8'h20, 0, 8'h20, 5, 1, 0);
    add(0, 1, 8'h20, 1, 8'h00, 5, 0, 0);
    // Done while idle ignored, withdrawal by owner ch4 with ch1 waiting
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h00, 1, 8'h00, 0, 0, 0);
    add(0, 1, 8'h10, 0, 8'h10, 4, 1, 0);
    add(0, 1, 8'h12, 0, 8'h10, 4, 1, 0);
    add(0, 1, 8'h02, 0, 8'h00, 4, 0, 0);
    add(0, 1, 8'h02, 0, 8'h02, 1, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].done);
      check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].valid, tbl[i].to);
    end

    // hold limit revoke, Timeout pulse, next scan from ch4
    hold_to_limit("timeout", 1'b0);
    check("timeout_pulse", 8'h00, 3'd3, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h18, 1'b0);
    check("timeout_next", 8'h10, 3'd4, 1'b1, 1'b0);

    // Done coincident with hold limit counts as Done
    hold_to_limit("done_to", 1'b1);
    check("done_to_release", 8'h00, 3'd3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("done_to_after", 8'h00, 3'd3, 1'b0, 1'b0);

    // En abort keeps Ptr, Rst mid-grant clears Ptr
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b1);
    step(1'b0, 1'b1, 8'h04, 1'b0);
    check("abort_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h04, 1'b0);
    check("abort_release", 8'h00, 3'd2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h0C, 1'b0);
    check("abort_ptr", 8'h04, 3'd2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h0C, 1'b0);
    check("rst_midgrant", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h09, 1'b0);
    check("rst_ptr", 8'h01, 3'd0, 1'b1, 1'b0);

    // random stimulus against the model
    model_step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      logic       r_rst, r_en, r_done;
      logic [7:0] r_req;
      r_rst  = ($urandom_range(99) == 0);
      r_en   = ($urandom_range(19) != 0);
      r_done = ($urandom_range(15) == 0);
      r_req  = ($urandom_range(7) == 0) ? 8'($urandom) : Req;
      model_step(r_rst, r_en, r_req, r_done);
      step(r_rst, r_en, r_req, r_done);
      check($sformatf("rand%0d", n), (m_owner >= 0) ? (8'h01 << m_last) : 8'h00,
            3'(m_last), (m_owner >= 0), m_to);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
